// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: period and high time in clock cycles,
// or a stuck-level report when no rising edge arrives within TIMEOUT cycles.
module pwm_capture #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 restart_i,
  input  logic                 pwm_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 stuck_o,
  output logic                 stuck_level_o,
  output logic                 sample_valid_o
);

  // IDLE: phase unknown | MEASURE: phase locked, reporting | STUCK: timed out, tracking level
  typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_STUCK} state_e;

  localparam logic [CNT_WIDTH-1:0] TimeoutC = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] OneC     = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 s1_q, s2_q, s3_q;
  logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 stuck_q, stuck_d;
  logic                 level_q, level_d;
  logic                 valid_q, valid_d;
  logic                 rise;
  logic                 tmo;

  assign rise = s2_q & ~s3_q;
  assign tmo  = (period_cnt_q == TimeoutC);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      stuck_q      <= 1'b0;
      level_q      <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      s1_q         <= pwm_i;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      stuck_q      <= stuck_d;
      level_q      <= level_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    stuck_d      = stuck_q;
    level_d      = level_q;
    valid_d      = 1'b0;

    if (restart_i) begin
      state_d      = ST_IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
    end else begin
      // Counters saturate at the timeout so a stuck input never wraps them.
      if (rise) begin
        period_cnt_d = OneC;
        high_cnt_d   = OneC;
      end else if (!tmo) begin
        period_cnt_d = period_cnt_q + OneC;
        high_cnt_d   = high_cnt_q + {{(CNT_WIDTH-1){1'b0}}, s2_q};
      end

      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_MEASURE;
          end else if (tmo) begin
            state_d  = ST_STUCK;
            period_d = '0;
            high_d   = '0;
            stuck_d  = 1'b1;
            level_d  = s2_q;
            valid_d  = 1'b1;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            period_d = period_cnt_q;
            high_d   = high_cnt_q;
            stuck_d  = 1'b0;
            level_d  = 1'b0;
            valid_d  = 1'b1;
          end else if (tmo) begin
            state_d  = ST_STUCK;
            period_d = '0;
            high_d   = '0;
            stuck_d  = 1'b1;
            level_d  = s2_q;
            valid_d  = 1'b1;
          end
        end
        ST_STUCK: begin
          if (rise) begin
            state_d = ST_MEASURE;
          end else begin
            level_d = s2_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign period_o       = period_q;
  assign high_o         = high_q;
  assign stuck_o        = stuck_q;
  assign stuck_level_o  = level_q;
  assign sample_valid_o = valid_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (TIMEOUT=20); samples are logged on the falling edge.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        pwm = 1'b0;
  logic [15:0] period_o, high_o;
  logic        stuck_o, stuck_level_o, sample_valid_o;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rel_cyc = 0;

  int q_per[$], q_high[$], q_stuck[$], q_lvl[$], q_cyc[$];
  int rise_q[$];

  pwm_capture #(.CNT_WIDTH(16), .TIMEOUT(20)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .restart_i      (restart),
    .pwm_i          (pwm),
    .period_o       (period_o),
    .high_o         (high_o),
    .stuck_o        (stuck_o),
    .stuck_level_o  (stuck_level_o),
    .sample_valid_o (sample_valid_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && sample_valid_o) begin
      q_per.push_back(int'(period_o));
      q_high.push_back(int'(high_o));
      q_stuck.push_back(int'(stuck_o));
      q_lvl.push_back(int'(stuck_level_o));
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    q_per.delete(); q_high.delete(); q_stuck.delete();
    q_lvl.delete(); q_cyc.delete(); rise_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pwm = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
    clear_log();
  endtask

  // Called on a falling edge; each period starts with a rising edge.
  task automatic pwm_wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      pwm = 1'b1;
      rise_q.push_back(cyc);
      repeat (h) @(negedge clk);
      pwm = 1'b0;
      repeat (p - h) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; pwm = 1'b1;
    #1;
    checks++; if (period_o !== 16'd0) $display("FAIL reset_period got=%0d exp=0", period_o); else passes++;
    checks++; if (high_o !== 16'd0) $display("FAIL reset_high got=%0d exp=0", high_o); else passes++;
    checks++; if (stuck_o !== 1'b0) $display("FAIL reset_stuck got=%0b exp=0", stuck_o); else passes++;
    checks++; if (stuck_level_o !== 1'b0) $display("FAIL reset_level got=%0b exp=0", stuck_level_o); else passes++;
    checks++; if (sample_valid_o !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", sample_valid_o); else passes++;
  endtask

  task automatic test_steady();
    do_reset();
    pwm_wave(10, 3, 6);
    checks++; if (q_per.size() != 5) $display("FAIL steady_count got=%0d exp=5", q_per.size()); else passes++;
    checks++;
    if (q_cyc.size() == 0 || q_cyc[0] != rise_q[1] + 3)
      $display("FAIL steady_latency got=%0d exp=%0d", (q_cyc.size() == 0) ? -1 : q_cyc[0], rise_q[1] + 3);
    else passes++;
    for (int i = 0; i < q_per.size(); i++) begin
      checks++; if (q_per[i] != 10) $display("FAIL steady_period[%0d] got=%0d exp=10", i, q_per[i]); else passes++;
      checks++; if (q_high[i] != 3) $display("FAIL steady_high[%0d] got=%0d exp=3", i, q_high[i]); else passes++;
      checks++; if (q_stuck[i] != 0) $display("FAIL steady_stuck[%0d] got=%0d exp=0", i, q_stuck[i]); else passes++;
      if (i > 0) begin
        checks++;
        if (q_cyc[i] - q_cyc[i-1] != 10) $display("FAIL steady_spacing[%0d] got=%0d exp=10", i, q_cyc[i] - q_cyc[i-1]);
        else passes++;
      end
    end
  endtask

  task automatic test_duty_change();
    int exp_h[5] = '{3, 3, 3, 7, 7};
    do_reset();
    pwm_wave(10, 3, 3);
    pwm_wave(10, 7, 3);
    checks++; if (q_per.size() != 5) $display("FAIL duty_count got=%0d exp=5", q_per.size()); else passes++;
    for (int i = 0; i < q_per.size() && i < 5; i++) begin
      checks++; if (q_high[i] != exp_h[i]) $display("FAIL duty_high[%0d] got=%0d exp=%0d", i, q_high[i], exp_h[i]); else passes++;
      checks++; if (q_per[i] != 10) $display("FAIL duty_period[%0d] got=%0d exp=10", i, q_per[i]); else passes++;
    end
  endtask

  task automatic test_stuck_low();
    do_reset();
    repeat (45) @(negedge clk);
    checks++; if (q_per.size() != 1) $display("FAIL stuck_low_count got=%0d exp=1", q_per.size()); else passes++;
    if (q_per.size() > 0) begin
      // Counter reaches 20 on the 20th edge after release; the report lands on edge 21.
      checks++; if (q_cyc[0] != rel_cyc + 21) $display("FAIL stuck_low_time got=%0d exp=%0d", q_cyc[0], rel_cyc + 21); else passes++;
      checks++; if (q_stuck[0] != 1) $display("FAIL stuck_low_flag got=%0d exp=1", q_stuck[0]); else passes++;
      checks++; if (q_lvl[0] != 0) $display("FAIL stuck_low_level got=%0d exp=0", q_lvl[0]); else passes++;
      checks++; if (q_per[0] != 0) $display("FAIL stuck_low_period got=%0d exp=0", q_per[0]); else passes++;
      checks++; if (q_high[0] != 0) $display("FAIL stuck_low_high got=%0d exp=0", q_high[0]); else passes++;
    end
    checks++; if (stuck_o !== 1'b1) $display("FAIL stuck_low_hold got=%0b exp=1", stuck_o); else passes++;
  endtask

  task automatic test_stuck_high();
    do_reset();
    pwm = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (q_per.size() != 1) $display("FAIL stuck_high_count got=%0d exp=1", q_per.size()); else passes++;
    if (q_per.size() > 0) begin
      checks++; if (q_stuck[0] != 1) $display("FAIL stuck_high_flag got=%0d exp=1", q_stuck[0]); else passes++;
      checks++; if (q_lvl[0] != 1) $display("FAIL stuck_high_level got=%0d exp=1", q_lvl[0]); else passes++;
      checks++; if (q_per[0] != 0) $display("FAIL stuck_high_period got=%0d exp=0", q_per[0]); else passes++;
    end
    clear_log();
    pwm = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (stuck_level_o !== 1'b0) $display("FAIL stuck_follow_level got=%0b exp=0", stuck_level_o); else passes++;
    checks++; if (stuck_o !== 1'b1) $display("FAIL stuck_after_fall got=%0b exp=1", stuck_o); else passes++;
    pwm_wave(8, 2, 3);
    checks++; if (q_per.size() != 2) $display("FAIL recover_count got=%0d exp=2", q_per.size()); else passes++;
    if (q_per.size() > 0) begin
      checks++; if (q_cyc[0] != rise_q[1] + 3) $display("FAIL recover_time got=%0d exp=%0d", q_cyc[0], rise_q[1] + 3); else passes++;
      checks++; if (q_per[0] != 8) $display("FAIL recover_period got=%0d exp=8", q_per[0]); else passes++;
      checks++; if (q_high[0] != 2) $display("FAIL recover_high got=%0d exp=2", q_high[0]); else passes++;
      checks++; if (q_stuck[0] != 0) $display("FAIL recover_stuck got=%0d exp=0", q_stuck[0]); else passes++;
    end
  endtask

  task automatic test_restart();
    do_reset();
    pwm_wave(10, 3, 3);
    pwm = 1'b1;
    repeat (3) @(negedge clk);
    pwm = 1'b0;
    repeat (2) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    checks++; if (period_o !== 16'd10) $display("FAIL restart_hold_period got=%0d exp=10", period_o); else passes++;
    checks++; if (high_o !== 16'd3) $display("FAIL restart_hold_high got=%0d exp=3", high_o); else passes++;
    checks++; if (sample_valid_o !== 1'b0) $display("FAIL restart_valid got=%0b exp=0", sample_valid_o); else passes++;
    restart = 1'b0;
    clear_log();
    repeat (5) @(negedge clk);
    pwm_wave(10, 3, 3);
    checks++; if (q_per.size() != 2) $display("FAIL restart_count got=%0d exp=2", q_per.size()); else passes++;
    if (q_per.size() > 0) begin
      checks++; if (q_cyc[0] != rise_q[1] + 3) $display("FAIL restart_time got=%0d exp=%0d", q_cyc[0], rise_q[1] + 3); else passes++;
      checks++; if (q_per[0] != 10) $display("FAIL restart_period got=%0d exp=10", q_per[0]); else passes++;
    end
  endtask

  // P equal to TIMEOUT: the rise lands on the same cycle as the timeout and must win.
  task automatic test_boundary();
    do_reset();
    pwm_wave(20, 5, 3);
    checks++; if (q_per.size() != 2) $display("FAIL bound_count got=%0d exp=2", q_per.size()); else passes++;
    for (int i = 0; i < q_per.size(); i++) begin
      checks++; if (q_per[i] != 20) $display("FAIL bound_period[%0d] got=%0d exp=20", i, q_per[i]); else passes++;
      checks++; if (q_high[i] != 5) $display("FAIL bound_high[%0d] got=%0d exp=5", i, q_high[i]); else passes++;
      checks++; if (q_stuck[i] != 0) $display("FAIL bound_stuck[%0d] got=%0d exp=0", i, q_stuck[i]); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pwm_wave(10, 3, 3);
    checks++; if (period_o !== 16'd10) $display("FAIL pre_reset_period got=%0d exp=10", period_o); else passes++;
    pwm = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (period_o !== 16'd0) $display("FAIL midrst_period got=%0d exp=0", period_o); else passes++;
    checks++; if (high_o !== 16'd0) $display("FAIL midrst_high got=%0d exp=0", high_o); else passes++;
    checks++; if (stuck_o !== 1'b0) $display("FAIL midrst_stuck got=%0b exp=0", stuck_o); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    pwm_wave(10, 3, 3);
    checks++; if (q_per.size() != 2) $display("FAIL midrst_count got=%0d exp=2", q_per.size()); else passes++;
    if (q_per.size() > 0) begin
      checks++; if (q_cyc[0] != rise_q[1] + 3) $display("FAIL midrst_time got=%0d exp=%0d", q_cyc[0], rise_q[1] + 3); else passes++;
      checks++; if (q_per[0] != 10) $display("FAIL midrst_sample_period got=%0d exp=10", q_per[0]); else passes++;
      checks++; if (q_high[0] != 3) $display("FAIL midrst_sample_high got=%0d exp=3", q_high[0]); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_duty_change();
    test_stuck_low();
    test_stuck_high();
    test_restart();
    test_boundary();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
